note_mem_responder: RTL and testbench

NOTE_MEM_RESPONDER -- requirements
Module: note_mem_responder

---
 rtl/note_mem_pkg.sv | 31 +++
 rtl/note_mem_array.sv | 38 +++
 rtl/note_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_note_mem_responder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_mem_pkg.sv
// rtl/note_mem_pkg.sv - shared types and encodings for the note memory responder
//
// Holds the responder state enum, the AHB-Lite HTRANS encodings and the HRESP
// OKAY/ERROR levels. NOTE_MEM_ERR_RESP_EN adds the two error-response states.
package note_mem_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

`ifdef NOTE_MEM_ERR_RESP_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA
   } state_t;
`endif

endpackage

// File: rtl/note_mem_array.sv
// rtl/note_mem_array.sv - DEPTH x 32 note storage, synchronous read, single write
//
// Ports:
//   clk      rising-edge clock
//   rd_en    capture mem[rd_addr] into rd_data on this edge
//   rd_addr  read word index
//   rd_data  registered read data (old contents when written on the same edge)
//   wr_en    write wr_data to mem[wr_addr] on this edge
//   wr_addr  write word index
//   wr_data  write data
// The storage is deliberately not reset.
module note_mem_array #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data
);

   logic [31:0] mem [DEPTH];

   // Both ports use non-blocking updates, so a read and a write of the same
   // word on one edge returns the pre-write contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/note_mem_responder.sv
// rtl/note_mem_responder.sv - AHB-Lite read-only responder over a CPU-loaded note memory
//
// Optional feature macro: NOTE_MEM_ERR_RESP_EN (adds HRESP and a two-cycle
// ERROR response for out-of-range and write transfers).
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   HADDR        byte address of the transfer
//   HTRANS       transfer type; only NONSEQ/SEQ start a data phase
//   HWRITE       transfer direction (writes never modify memory)
//   HRDATA       read data, held between data phases
//   HREADY       data phase done / address phase qualifier
//   HRESP        OKAY/ERROR (only with NOTE_MEM_ERR_RESP_EN)
//   ld_en        CPU load strobe
//   ld_addr      CPU load word index
//   ld_data      CPU load data
module note_mem_responder
   import note_mem_pkg::*;
#(
   parameter int          DEPTH       = 256,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   localparam int         AW          = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   HADDR,
   input  logic [1:0]    HTRANS,
   input  logic          HWRITE,
   output logic [31:0]   HRDATA,
   output logic          HREADY,
`ifdef NOTE_MEM_ERR_RESP_EN
   output logic          HRESP,
`endif
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [31:0]   ld_data
);

   localparam logic [31:0] DEPTH_WORDS = 32'(DEPTH);
   // The counter is loaded with WAIT_STATES-1 so that WAIT lasts exactly
   // WAIT_STATES cycles, leaving on the edge where it reads zero.
   localparam logic [3:0]  CNT_LOAD    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t        state;
   state_t        state_nxt;
   state_t        accept_state;
   logic [3:0]    wait_cnt;
   logic          zero_q;
   logic [31:0]   hold_q;
   logic [31:0]   rd_q;
   logic [31:0]   offset;
   logic          out_of_range;
   logic          bad_xfer;
   logic          accept;
   logic [AW-1:0] rd_idx;

   assign offset       = HADDR - BASE_ADDR;
   assign out_of_range = (HADDR < BASE_ADDR) || ((offset >> 2) >= DEPTH_WORDS);
   assign bad_xfer     = out_of_range | HWRITE;
   assign rd_idx       = offset[AW+1:2];
   assign accept       = HREADY & HTRANS[1];

   // HREADY depends only on the state register so the accept term never loops
   // back through the next-state logic.
`ifdef NOTE_MEM_ERR_RESP_EN
   assign HREADY = (state != ST_WAIT) && (state != ST_ERR1);
`else
   assign HREADY = (state != ST_WAIT);
`endif

   // Inside DATA the registered array word is shown directly (or zero for a
   // rejected transfer); everywhere else the value from the last DATA is held.
   assign HRDATA = (state == ST_DATA) ? (zero_q ? 32'd0 : rd_q) : hold_q;

   note_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .rd_en   (accept & ~bad_xfer),
      .rd_addr (rd_idx),
      .rd_data (rd_q),
      .wr_en   (ld_en),
      .wr_addr (ld_addr),
      .wr_data (ld_data)
   );

   always_comb begin
      accept_state = ST_DATA;
`ifdef NOTE_MEM_ERR_RESP_EN
      if (bad_xfer) begin
         accept_state = ST_ERR1;
      end else
`endif
      if (WAIT_STATES > 0) begin
         accept_state = ST_WAIT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

`ifdef NOTE_MEM_ERR_RESP_EN
   logic hresp_c;
   assign HRESP = hresp_c;
`endif

   always_comb begin
      state_nxt = state;
`ifdef NOTE_MEM_ERR_RESP_EN
      hresp_c   = HRESP_OKAY;
`endif
      case (state)
         ST_WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_nxt = ST_DATA;
            end
         end
`ifdef NOTE_MEM_ERR_RESP_EN
         ST_ERR1: begin
            hresp_c   = HRESP_ERROR;
            state_nxt = ST_ERR2;
         end
         ST_ERR2: begin
            hresp_c   = HRESP_ERROR;
            state_nxt = accept ? accept_state : ST_IDLE;
         end
`endif
         default: begin
            // IDLE and DATA: a new address phase may be taken on this edge.
            state_nxt = accept ? accept_state : ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 4'd0;
         zero_q   <= 1'b0;
         hold_q   <= 32'd0;
      end else begin
         if (accept) begin
            wait_cnt <= CNT_LOAD;
            zero_q   <= bad_xfer;
         end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (state == ST_DATA) begin
            hold_q <= HRDATA;
         end
      end
   end

endmodule

// File: tb/tb_note_mem_responder.sv
// tb/tb_note_mem_responder.sv - self-checking bench for note_mem_responder (zero-wait and two-wait instances)
`timescale 1ns/1ps
module tb_note_mem_responder;
   import note_mem_pkg::*;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] haddr_a, haddr_b;
   logic [1:0]  htrans_a, htrans_b;
   logic        hwrite_a, hwrite_b;
   logic [31:0] hrdata_a, hrdata_b;
   logic        hready_a, hready_b;
`ifdef NOTE_MEM_ERR_RESP_EN
   logic        hresp_a, hresp_b;
`endif
   logic        ld_en;
   logic [7:0]  ld_addr;
   logic [31:0] ld_data;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] last_data [2];

   always #5 clk = ~clk;

   note_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut_a (
      .clk(clk), .rst_n(rst_n), .HADDR(haddr_a), .HTRANS(htrans_a), .HWRITE(hwrite_a),
      .HRDATA(hrdata_a), .HREADY(hready_a),
`ifdef NOTE_MEM_ERR_RESP_EN
      .HRESP(hresp_a),
`endif
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

   note_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut_b (
      .clk(clk), .rst_n(rst_n), .HADDR(haddr_b), .HTRANS(htrans_b), .HWRITE(hwrite_b),
      .HRDATA(hrdata_b), .HREADY(hready_b),
`ifdef NOTE_MEM_ERR_RESP_EN
      .HRESP(hresp_b),
`endif
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

   function automatic logic rdy(int w);
      return (w == 0) ? hready_a : hready_b;
   endfunction

   function automatic logic [31:0] rdat(int w);
      return (w == 0) ? hrdata_a : hrdata_b;
   endfunction

`ifdef NOTE_MEM_ERR_RESP_EN
   function automatic logic resp(int w);
      return (w == 0) ? hresp_a : hresp_b;
   endfunction
`endif

   function automatic int waits_of(int w);
      return (w == 0) ? 0 : 2;
   endfunction

   function automatic logic is_bad(logic [31:0] addr, logic hw);
      return hw || ((addr >> 2) >= 32'(DEPTH));
   endfunction

   function automatic logic [31:0] model_read(logic [31:0] addr, logic hw);
      int idx;
      idx = int'(addr >> 2);
      if (is_bad(addr, hw)) return 32'd0;
      return ref_mem[idx];
   endfunction

   task automatic drive(int w, logic [31:0] a, logic [1:0] t, logic hw);
      if (w == 0) begin
         haddr_a = a; htrans_a = t; hwrite_a = hw;
      end else begin
         haddr_b = a; htrans_b = t; hwrite_b = hw;
      end
   endtask

   task automatic load_word(int idx, logic [31:0] data);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 8'(idx); ld_data = data;
      @(posedge clk);
      #1 ld_en = 1'b0;
      ref_mem[idx] = data;
   endtask

   task automatic issue(int w, logic [31:0] addr, logic hw);
      @(negedge clk);
      drive(w, addr, HTRANS_NONSEQ, hw);
   endtask

   // Follows a transfer whose address phase is on the coming rising edge and
   // returns at the negedge of its final (HREADY=1) cycle.
   task automatic complete(int w, logic [31:0] addr, logic hw, string name);
      logic [31:0] exp;
      int          n;
      exp = model_read(addr, hw);
      @(negedge clk);
      drive(w, 32'h0, HTRANS_IDLE, 1'b0);
`ifdef NOTE_MEM_ERR_RESP_EN
      if (is_bad(addr, hw)) begin
         n_tests++;
         if (rdy(w) !== 1'b0 || resp(w) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s err1: hready=%b hresp=%b expected hready=0 hresp=1", name, rdy(w), resp(w));
         end
         @(negedge clk);
         n_tests++;
         if (rdy(w) !== 1'b1 || resp(w) !== 1'b1 || rdat(w) !== last_data[w]) begin
            n_fail++;
            $display("FAIL %s err2: hready=%b hresp=%b hrdata=%h expected 1 1 %h",
                     name, rdy(w), resp(w), rdat(w), last_data[w]);
         end
         return;
      end
`endif
      n = 0;
      while (rdy(w) !== 1'b1 && n < 40) begin
         n_tests++;
         if (rdat(w) !== last_data[w]) begin
            n_fail++;
            $display("FAIL %s hold: hrdata=%h expected %h", name, rdat(w), last_data[w]);
         end
         n++;
         @(negedge clk);
      end
      n_tests++;
      if (n !== waits_of(w)) begin
         n_fail++;
         $display("FAIL %s waits: got %0d expected %0d", name, n, waits_of(w));
      end
      n_tests++;
      if (rdat(w) !== exp) begin
         n_fail++;
         $display("FAIL %s data: got %h expected %h", name, rdat(w), exp);
      end
`ifdef NOTE_MEM_ERR_RESP_EN
      n_tests++;
      if (resp(w) !== HRESP_OKAY) begin
         n_fail++;
         $display("FAIL %s resp: got %b expected 0", name, resp(w));
      end
`endif
      last_data[w] = exp;
   endtask

   task automatic test_reset();
      drive(0, 32'h0, HTRANS_IDLE, 1'b0);
      drive(1, 32'h0, HTRANS_IDLE, 1'b0);
      ld_en = 1'b0; ld_addr = 8'h0; ld_data = 32'h0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         n_tests++;
         if (rdy(w) !== 1'b1 || rdat(w) !== 32'd0) begin
            n_fail++;
            $display("FAIL reset dut%0d: hready=%b hrdata=%h expected 1 00000000", w, rdy(w), rdat(w));
         end
`ifdef NOTE_MEM_ERR_RESP_EN
         n_tests++;
         if (resp(w) !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resp dut%0d: got %b expected 0", w, resp(w));
         end
`endif
         last_data[w] = 32'd0;
      end
      rst_n = 1'b1;
   endtask

   task automatic preload();
      for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
   endtask

   task automatic test_zero_wait();
      load_word(3, 32'h0000_0A15);
      issue(0, 32'h0000_000C, 1'b0);
      complete(0, 32'h0000_000C, 1'b0, "zero_wait");
      n_tests++;
      if (hrdata_a !== 32'h0000_0A15) begin
         n_fail++;
         $display("FAIL zero_wait_const: got %h expected 00000a15", hrdata_a);
      end
   endtask

   task automatic test_back_to_back();
      load_word(5, $urandom);
      load_word(6, $urandom);
      issue(1, 32'h14, 1'b0);
      complete(1, 32'h14, 1'b0, "wait2_idx5");
      drive(1, 32'h18, HTRANS_NONSEQ, 1'b0);
      complete(1, 32'h18, 1'b0, "b2b_idx6");
      issue(0, 32'h14, 1'b0);
      complete(0, 32'h14, 1'b0, "z_idx5");
      drive(0, 32'h18, HTRANS_SEQ, 1'b0);
      complete(0, 32'h18, 1'b0, "z_b2b_idx6");
   endtask

   task automatic test_read_before_write();
      logic [31:0] nv;
      nv = ~ref_mem[7];
      @(negedge clk);
      drive(1, 32'h1C, HTRANS_NONSEQ, 1'b0);
      ld_en = 1'b1; ld_addr = 8'd7; ld_data = nv;
      @(posedge clk);
      #1 ld_en = 1'b0;
      complete(1, 32'h1C, 1'b0, "rbw_old");
      ref_mem[7] = nv;
      issue(1, 32'h1C, 1'b0);
      complete(1, 32'h1C, 1'b0, "rbw_new");
   endtask

   task automatic test_reject();
      for (int w = 0; w < 2; w++) begin
         issue(w, 32'h0000_0400, 1'b0);
         complete(w, 32'h0000_0400, 1'b0, "oor_0x400");
         issue(w, 32'h0000_0020, 1'b1);
         complete(w, 32'h0000_0020, 1'b1, "write_xfer");
         issue(w, 32'h0000_0020, 1'b0);
         complete(w, 32'h0000_0020, 1'b0, "after_write");
         issue(w, 32'h0000_03FF, 1'b0);
         complete(w, 32'h0000_03FF, 1'b0, "last_word");
      end
   endtask

   task automatic test_idle_busy();
      for (int w = 0; w < 2; w++) begin
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(w, 32'h10, (k == 0) ? HTRANS_BUSY : HTRANS_IDLE, 1'b0);
            repeat (3) begin
               @(negedge clk);
               n_tests++;
               if (rdy(w) !== 1'b1 || rdat(w) !== last_data[w]) begin
                  n_fail++;
                  $display("FAIL idle_busy dut%0d: hready=%b hrdata=%h expected 1 %h", w, rdy(w), rdat(w), last_data[w]);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      load_word(9, 32'hDEAD_BEEF);
      issue(1, 32'h24, 1'b0);
      complete(1, 32'h24, 1'b0, "pre_reset");
      issue(1, 32'h28, 1'b0);
      @(negedge clk);
      drive(1, 32'h0, HTRANS_IDLE, 1'b0);
      n_tests++;
      if (hready_b !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_wait_state: hready=%b expected 0", hready_b);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (hready_b !== 1'b1 || hrdata_b !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid_wait: hready=%b hrdata=%h expected 1 00000000", hready_b, hrdata_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      last_data[0] = 32'd0;
      last_data[1] = 32'd0;
      issue(1, 32'h24, 1'b0);
      complete(1, 32'h24, 1'b0, "post_reset");
   endtask

   task automatic test_random();
      int          w;
      int          r;
      logic [31:0] a;
      logic        hw;
      for (int i = 0; i < 60; i++) begin
         w = (i < 30) ? (i % 2) : int'($urandom_range(0, 1));
         r = int'($urandom_range(0, 9));
         if (r < 7)       a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom)};
         else if (r == 7) a = 32'h400 + $urandom_range(0, 32'hFFF);
         else             a = $urandom;
         hw = ($urandom_range(0, 7) == 0);
         if (i > 0 && $urandom_range(0, 1) == 1) begin
            drive(w, a, HTRANS_NONSEQ, hw);
         end else begin
            if ($urandom_range(0, 2) == 0) load_word(int'($urandom_range(0, 255)), $urandom);
            issue(w, a, hw);
         end
         complete(w, a, hw, "random");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      preload();
      test_zero_wait();
      test_back_to_back();
      test_read_before_write();
      test_reject();
      test_idle_busy();
      test_reset_mid_wait();
      test_random();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
